pf_ddr4_dqs_tx_seq: RTL and testbench
=====================================

# pf_ddr4_dqs_tx_seq

Fabric-side DQS write-strobe sequencer for one DDR4 byte lane. Runs on the lane fabric clock and drives the DQS IOD transmit inputs: 8-beat serialized TX data, 4-bit output-enable data and the ODT enable. On each accepted write command it generates write preamble, N back-to-back BL8 toggle bursts and postamble. It sits between the DDR controller write scheduler and the DQS lane IOD.

## Interface
- PREAMBLE_2TCK, 0, 0 = 1tCK write preamble, 1 = 2tCK write preamble
- NBURST_W, 4, width of burst-count field; maximum bursts per command = 2^NBURST_W-1
- FAB_CLK  in  1  lane fabric clock; one cycle = 8 DQ beats = 4 tCK
- ARST_N  in  1  reset, asynchronous, active-low
- TX_SYNC_RST  in  1  synchronous clear to IDLE, same effect as reset but on the clock edge
- WR_VALID  in  1  write command valid
- WR_NBURST  in  NBURST_W  number of consecutive BL8 bursts; 0 is treated as 1
- WR_READY  out  1  command accepted when WR_VALID && WR_READY at a FAB_CLK edge
- RD_ODT_REQ  in  1  read-side request for lane ODT
- TX_DATA_0  out  8  DQS beat pattern to IOD, bit 0 serialized first
- OE_DATA_0  out  4  DQS output enable to IOD, bit k covers beats 2k and 2k+1
- ODT_EN_0  out  1  ODT enable to IOD
- BUSY  out  1  high in any state other than IDLE
- BURST_DONE  out  1  one-cycle pulse during the final BURST cycle of a command

## Operation
- FSM states: IDLE, PRE, BURST, POST.
- IDLE: accept -> PRE. The burst counter loads max(WR_NBURST,1).
- PRE: always exactly one cycle -> BURST.
- BURST: the counter decrements each cycle. At count 1, either a new accept occurs (counter reloads, stay in BURST, seamless, no postamble or preamble) or the FSM moves to POST.
- POST: one cycle. An accept in POST -> PRE, otherwise -> IDLE.
- WR_READY = (state==IDLE || state==POST || (state==BURST && count==1)) && !TX_SYNC_RST. It is combinational from registered state.
- Registered outputs, driven during the cycle the state is occupied:
  - IDLE: TX_DATA_0=8'h00, OE_DATA_0=4'h0.
  - PRE with 1tCK: OE_DATA_0=4'b1000, TX_DATA_0=8'h00.
  - PRE with 2tCK: OE_DATA_0=4'b1100, TX_DATA_0=8'b0001_0000.
  - BURST: OE_DATA_0=4'b1111, TX_DATA_0=8'b0101_0101.
  - POST: OE_DATA_0=4'b0001, TX_DATA_0=8'h00.
- ODT_EN_0 is registered: next = RD_ODT_REQ && next_state==IDLE. ODT is never asserted in a cycle where OE_DATA_0 is nonzero.
- WR_NBURST is sampled only at accept. Changes at other times are ignored.
- WR_VALID without WR_READY is held off and has no effect.

## Timing
- Reset (ARST_N low, asynchronous): state IDLE, count 0, TX_DATA_0=8'h00, OE_DATA_0=4'h0, ODT_EN_0=0, BUSY=0, BURST_DONE=0. WR_READY=1 once ARST_N deasserts.
- Accept at edge E0 gives: PRE during cycle E0..E1, then bursts during cycles E1..E1+N, then POST in the following cycle unless chained.
- Latency is 1 cycle from accept to the first nonzero OE_DATA_0, and 2 cycles from accept to the first burst beat.
- Chained accept in the last BURST cycle: the next cycle is BURST with an unbroken 8'b0101_0101 pattern.
- Accept in POST: cycle sequence is POST, PRE, BURST. The gap is one cycle and is not merged.
- TX_SYNC_RST high at an edge: next state IDLE and all outputs return to their reset values, even mid-burst. No postamble is emitted. A WR_VALID in that cycle is not accepted.
- ARST_N asserted mid-operation: outputs go to reset values immediately, without waiting for a clock edge.
- BURST_DONE asserts in the final BURST cycle of every command, including each chained command.

## Test plan
- Reset then single command, WR_NBURST=1, 1tCK preamble -> OE sequence 1000, 1111, 0001, 0000; TX sequence 00, 55, 00, 00; BUSY high for 3 cycles; one BURST_DONE.
- WR_NBURST=3 with PREAMBLE_2TCK=1 -> PRE OE=1100 TX=0x10, then 3 cycles of OE=1111 TX=0x55, then POST OE=0001.
- Chained commands: N=2 then an accept in the last BURST cycle with N=1 -> 3 contiguous BURST cycles, no PRE or POST between them, two BURST_DONE pulses.
- Accept in POST, and WR_NBURST=0 -> POST, PRE, one BURST cycle (0 treated as 1).
- TX_SYNC_RST asserted in the 2nd BURST cycle of an N=4 command -> next cycle OE=0, TX=0, IDLE, WR_READY=1. Separately, ARST_N pulsed low mid-burst -> outputs clear asynchronously.
- RD_ODT_REQ held high across a command -> ODT_EN_0=1 in IDLE, 0 in every PRE/BURST/POST cycle, and 1 again the cycle after returning to IDLE.

Source files
------------

// File: rtl/pf_ddr4_dqs_tx_seq.sv
// DQS write-strobe sequencer for one DDR4 byte lane.
// Emits preamble, chained BL8 toggle bursts and postamble per write command.
module pf_ddr4_dqs_tx_seq #(
    parameter int PREAMBLE_2TCK = 0,
    parameter int NBURST_W      = 4
) (
    input  logic                FAB_CLK,
    input  logic                ARST_N,
    input  logic                TX_SYNC_RST,
    input  logic                WR_VALID,
    input  logic [NBURST_W-1:0] WR_NBURST,
    output logic                WR_READY,
    input  logic                RD_ODT_REQ,
    output logic [7:0]          TX_DATA_0,
    output logic [3:0]          OE_DATA_0,
    output logic                ODT_EN_0,
    output logic                BUSY,
    output logic                BURST_DONE
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRE   = 2'd1,
        BURST = 2'd2,
        POST  = 2'd3
    } state_t;

    localparam logic [NBURST_W-1:0] CNT_ONE = NBURST_W'(1);

    localparam logic [3:0] PRE_OE = (PREAMBLE_2TCK != 0) ? 4'b1100 : 4'b1000;
    localparam logic [7:0] PRE_TX = (PREAMBLE_2TCK != 0) ? 8'b0001_0000 : 8'h00;

    state_t              state;
    state_t              state_n;
    logic [NBURST_W-1:0] count;
    logic [NBURST_W-1:0] count_n;
    logic [NBURST_W-1:0] nb_eff;
    logic                last;
    logic                accept;
    logic [7:0]          tx_n;
    logic [3:0]          oe_n;
    logic                odt_n;

    assign last   = (state == BURST) && (count == CNT_ONE);
    assign nb_eff = (WR_NBURST == '0) ? CNT_ONE : WR_NBURST;

    assign WR_READY   = ((state == IDLE) || (state == POST) || last) && !TX_SYNC_RST;
    assign accept     = WR_VALID && WR_READY;
    assign BUSY       = (state != IDLE);
    assign BURST_DONE = last;

    always_comb begin
        state_n = state;
        count_n = count;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    state_n = PRE;
                    count_n = nb_eff;
                end
            end
            PRE: begin
                state_n = BURST;
            end
            BURST: begin
                if (last) begin
                    if (accept) begin
                        count_n = nb_eff;
                    end else begin
                        state_n = POST;
                        count_n = '0;
                    end
                end else begin
                    count_n = count - CNT_ONE;
                end
            end
            POST: begin
                if (accept) begin
                    state_n = PRE;
                    count_n = nb_eff;
                end else begin
                    state_n = IDLE;
                end
            end
        endcase
        if (TX_SYNC_RST) begin
            state_n = IDLE;
            count_n = '0;
        end
    end

    // IOD inputs are registered from the state being entered
    always_comb begin
        tx_n = 8'h00;
        oe_n = 4'h0;
        unique case (state_n)
            IDLE: begin
                tx_n = 8'h00;
                oe_n = 4'h0;
            end
            PRE: begin
                tx_n = PRE_TX;
                oe_n = PRE_OE;
            end
            BURST: begin
                tx_n = 8'b0101_0101;
                oe_n = 4'b1111;
            end
            POST: begin
                tx_n = 8'h00;
                oe_n = 4'b0001;
            end
        endcase
        odt_n = RD_ODT_REQ && (state_n == IDLE);
    end

    always_ff @(posedge FAB_CLK or negedge ARST_N) begin
        if (!ARST_N) begin
            state     <= IDLE;
            count     <= '0;
            TX_DATA_0 <= 8'h00;
            OE_DATA_0 <= 4'h0;
            ODT_EN_0  <= 1'b0;
        end else begin
            state     <= state_n;
            count     <= count_n;
            TX_DATA_0 <= tx_n;
            OE_DATA_0 <= oe_n;
            ODT_EN_0  <= odt_n;
        end
    end

endmodule

// File: tb/tb_pf_ddr4_dqs_tx_seq.sv
// Directed bench for pf_ddr4_dqs_tx_seq.
// Two instances differ only in preamble length and share all inputs.
module tb_pf_ddr4_dqs_tx_seq;

    localparam int NW = 4;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_PRE   = 2'd1;
    localparam logic [1:0] S_BURST = 2'd2;
    localparam logic [1:0] S_POST  = 2'd3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          sync_rst;
    logic          wr_valid;
    logic [NW-1:0] wr_nburst;
    logic          odt_req;

    logic          rdy_a, rdy_b;
    logic [7:0]    tx_a, tx_b;
    logic [3:0]    oe_a, oe_b;
    logic          odt_a, odt_b;
    logic          busy_a, busy_b;
    logic          done_a, done_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pf_ddr4_dqs_tx_seq #(.PREAMBLE_2TCK(0), .NBURST_W(NW)) dut_a (
        .FAB_CLK     (clk),
        .ARST_N      (rst_n),
        .TX_SYNC_RST (sync_rst),
        .WR_VALID    (wr_valid),
        .WR_NBURST   (wr_nburst),
        .WR_READY    (rdy_a),
        .RD_ODT_REQ  (odt_req),
        .TX_DATA_0   (tx_a),
        .OE_DATA_0   (oe_a),
        .ODT_EN_0    (odt_a),
        .BUSY        (busy_a),
        .BURST_DONE  (done_a)
    );

    pf_ddr4_dqs_tx_seq #(.PREAMBLE_2TCK(1), .NBURST_W(NW)) dut_b (
        .FAB_CLK     (clk),
        .ARST_N      (rst_n),
        .TX_SYNC_RST (sync_rst),
        .WR_VALID    (wr_valid),
        .WR_NBURST   (wr_nburst),
        .WR_READY    (rdy_b),
        .RD_ODT_REQ  (odt_req),
        .TX_DATA_0   (tx_b),
        .OE_DATA_0   (oe_b),
        .ODT_EN_0    (odt_b),
        .BUSY        (busy_b),
        .BURST_DONE  (done_b)
    );

    task automatic cmp(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk(input string tag, input logic [1:0] st,
                       input logic done, input logic rdy, input logic odt);
        logic [3:0] eoa, eob;
        logic [7:0] eta, etb;
        case (st)
            S_PRE:   begin eoa = 4'b1000; eta = 8'h00; eob = 4'b1100; etb = 8'h10; end
            S_BURST: begin eoa = 4'b1111; eta = 8'h55; eob = 4'b1111; etb = 8'h55; end
            S_POST:  begin eoa = 4'b0001; eta = 8'h00; eob = 4'b0001; etb = 8'h00; end
            default: begin eoa = 4'h0;    eta = 8'h00; eob = 4'h0;    etb = 8'h00; end
        endcase
        cmp({tag, ".oe_a"}, {4'h0, oe_a}, {4'h0, eoa});
        cmp({tag, ".tx_a"}, tx_a, eta);
        cmp({tag, ".oe_b"}, {4'h0, oe_b}, {4'h0, eob});
        cmp({tag, ".tx_b"}, tx_b, etb);
        cmp({tag, ".busy"}, {6'h0, busy_a, busy_b}, {6'h0, st != S_IDLE, st != S_IDLE});
        cmp({tag, ".done"}, {6'h0, done_a, done_b}, {6'h0, done, done});
        cmp({tag, ".ready"}, {6'h0, rdy_a, rdy_b}, {6'h0, rdy, rdy});
        cmp({tag, ".odt"}, {6'h0, odt_a, odt_b}, {6'h0, odt, odt});
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n     = 1'b0;
        sync_rst  = 1'b0;
        wr_valid  = 1'b0;
        wr_nburst = '0;
        odt_req   = 1'b0;
        #12;
        chk("reset", S_IDLE, 0, 1, 0);
        rst_n = 1'b1;
        cyc();
        chk("idle0", S_IDLE, 0, 1, 0);

        // single burst, N=1
        wr_valid = 1'b1; wr_nburst = 4'd1;
        cyc();
        wr_valid = 1'b0;
        chk("t1.pre", S_PRE, 0, 0, 0);
        cyc(); chk("t1.burst", S_BURST, 1, 1, 0);
        cyc(); chk("t1.post", S_POST, 0, 1, 0);
        cyc(); chk("t1.idle", S_IDLE, 0, 1, 0);

        // N=3, burst count changes after accept are ignored
        wr_valid = 1'b1; wr_nburst = 4'd3;
        cyc();
        wr_valid = 1'b0; wr_nburst = 4'd7;
        chk("t2.pre", S_PRE, 0, 0, 0);
        cyc(); chk("t2.b1", S_BURST, 0, 0, 0);
        cyc(); chk("t2.b2", S_BURST, 0, 0, 0);
        cyc(); chk("t2.b3", S_BURST, 1, 1, 0);
        cyc(); chk("t2.post", S_POST, 0, 1, 0);
        cyc(); chk("t2.idle", S_IDLE, 0, 1, 0);

        // chained: N=2 then N=1 accepted in the last burst cycle
        wr_valid = 1'b1; wr_nburst = 4'd2;
        cyc();
        wr_valid = 1'b0;
        chk("t3.pre", S_PRE, 0, 0, 0);
        cyc();
        chk("t3.b1", S_BURST, 0, 0, 0);
        wr_valid = 1'b1; wr_nburst = 4'd5;
        cyc();
        chk("t3.b2", S_BURST, 1, 1, 0);
        wr_nburst = 4'd1;
        cyc();
        wr_valid = 1'b0;
        chk("t3.b3", S_BURST, 1, 1, 0);
        cyc(); chk("t3.post", S_POST, 0, 1, 0);
        cyc(); chk("t3.idle", S_IDLE, 0, 1, 0);

        // accept in POST with N=0
        wr_valid = 1'b1; wr_nburst = 4'd1;
        cyc();
        wr_valid = 1'b0;
        chk("t4.pre", S_PRE, 0, 0, 0);
        cyc(); chk("t4.b1", S_BURST, 1, 1, 0);
        cyc();
        chk("t4.post", S_POST, 0, 1, 0);
        wr_valid = 1'b1; wr_nburst = 4'd0;
        cyc();
        wr_valid = 1'b0;
        chk("t4.pre2", S_PRE, 0, 0, 0);
        cyc(); chk("t4.b2", S_BURST, 1, 1, 0);
        cyc(); chk("t4.post2", S_POST, 0, 1, 0);
        cyc(); chk("t4.idle", S_IDLE, 0, 1, 0);

        // synchronous clear in 2nd burst cycle of N=4
        wr_valid = 1'b1; wr_nburst = 4'd4;
        cyc();
        wr_valid = 1'b0;
        chk("t5.pre", S_PRE, 0, 0, 0);
        cyc(); chk("t5.b1", S_BURST, 0, 0, 0);
        cyc(); chk("t5.b2", S_BURST, 0, 0, 0);
        sync_rst = 1'b1; wr_valid = 1'b1;
        #1;
        chk("t5.sync_hi", S_BURST, 0, 0, 0);
        cyc();
        chk("t5.cleared", S_IDLE, 0, 0, 0);
        sync_rst = 1'b0; wr_valid = 1'b0;
        #1;
        chk("t5.ready", S_IDLE, 0, 1, 0);
        cyc(); chk("t5.idle", S_IDLE, 0, 1, 0);

        // asynchronous reset mid-burst
        wr_valid = 1'b1; wr_nburst = 4'd4;
        cyc();
        wr_valid = 1'b0;
        cyc();
        chk("t6.b1", S_BURST, 0, 0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6.arst", S_IDLE, 0, 1, 0);
        cyc();
        rst_n = 1'b1;
        chk("t6.held", S_IDLE, 0, 1, 0);
        cyc(); chk("t6.idle", S_IDLE, 0, 1, 0);

        // ODT request held across a command
        odt_req = 1'b1;
        cyc();
        chk("t7.idle", S_IDLE, 0, 1, 1);
        wr_valid = 1'b1; wr_nburst = 4'd1;
        cyc();
        wr_valid = 1'b0;
        chk("t7.pre", S_PRE, 0, 0, 0);
        cyc(); chk("t7.burst", S_BURST, 1, 1, 0);
        cyc(); chk("t7.post", S_POST, 0, 1, 0);
        cyc(); chk("t7.idle2", S_IDLE, 0, 1, 1);
        odt_req = 1'b0;
        cyc(); chk("t7.off", S_IDLE, 0, 1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

endmodule
